// File: rtl/mux_gate_reduce_pipe_pkg.sv
// Shared types and elaboration helpers for the mux-built reduction pipeline.
package mux_gate_pkg;

   typedef enum logic [1:0] {
      OP_OR  = 2'b00,
      OP_AND = 2'b01,
      OP_XOR = 2'b10,
      OP_RSV = 2'b11
   } reduce_op_t;

   // A usable input count is a power of two with at least one tree level.
   function automatic bit n_in_ok(input int n);
      return (n >= 32'sd2) && ((n & (n - 32'sd1)) == 32'sd0);
   endfunction

endpackage

// File: rtl/mux_gate_reduce_pipe_cell.sv
// W-bit two-input OR/AND/XOR gate built purely from 2:1 mux cells,
// constants and inverters; the reserved op behaves as OR.
module mux_gate_mux2 (
   input  logic s,
   input  logic d0,
   input  logic d1,
   output logic y
);
   assign y = s ? d1 : d0;
endmodule

module mux_gate_cell
   import mux_gate_pkg::*;
#(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  reduce_op_t   op,
   output logic [W-1:0] y
);

   logic is_and_s;
   logic is_xor_s;

   // Decode the op into the two mux selects shared by every bit.
   always_comb begin
      is_and_s = 1'b0;
      is_xor_s = 1'b0;
      case (op)
         OP_AND:  is_and_s = 1'b1;
         OP_XOR:  is_xor_s = 1'b1;
         default: begin
            is_and_s = 1'b0;
            is_xor_s = 1'b0;
         end
      endcase
   end

   // y = a ? hi : lo, with hi/lo being 1/b (OR), b/0 (AND) or ~b/b (XOR).
   for (genvar k = 0; k < W; k++) begin : g_bit
      logic nb_s;
      logic hi_xor_s;
      logic hi_s;
      logic lo_s;

      assign nb_s = ~b[k];

      mux_gate_mux2 u_hi_xor (.s(is_xor_s), .d0(1'b1),     .d1(nb_s),   .y(hi_xor_s));
      mux_gate_mux2 u_hi     (.s(is_and_s), .d0(hi_xor_s), .d1(b[k]),   .y(hi_s));
      mux_gate_mux2 u_lo     (.s(is_and_s), .d0(b[k]),     .d1(1'b0),   .y(lo_s));
      mux_gate_mux2 u_out    (.s(a[k]),     .d0(lo_s),     .d1(hi_s),   .y(y[k]));
   end

endmodule

// File: rtl/mux_gate_reduce_pipe.sv
// Pipelined N_IN-way bitwise reduction tree; one registered stage per tree
// level with a valid/ready stall chain that keeps full throughput.
module mux_gate_reduce_pipe
   import mux_gate_pkg::*;
#(
   parameter int N_IN = 8,
   parameter int W    = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [N_IN*W-1:0] in_data,
   input  logic [1:0]        in_op,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [W-1:0]      out_data,
   output logic [1:0]        out_op
);

   localparam int LVL = $clog2(N_IN);

   if (!n_in_ok(N_IN)) begin : g_bad_n_in
      $error("mux_gate_reduce_pipe: N_IN=%0d must be a power of two >= 2", N_IN);
   end

   // rdy_s[j] is the load enable of stage j; the top bit is the consumer.
   logic [LVL:0] rdy_s;

   assign rdy_s[LVL] = out_ready;
   assign in_ready   = rdy_s[0];

   for (genvar j = 0; j < LVL; j++) begin : g_lvl
      localparam int NO = N_IN >> (j + 1);

      logic [2*NO*W-1:0] src_data_s;
      logic              src_valid_s;
      reduce_op_t        src_op_s;
      logic [NO*W-1:0]   res_s;
      logic [NO*W-1:0]   data_r;
      logic              valid_r;
      reduce_op_t        op_r;

      if (j == 0) begin : g_src_in
         assign src_data_s  = in_data;
         assign src_valid_s = in_valid;
         assign src_op_s    = reduce_op_t'(in_op);
      end else begin : g_src_prev
         assign src_data_s  = g_lvl[j-1].data_r;
         assign src_valid_s = g_lvl[j-1].valid_r;
         assign src_op_s    = g_lvl[j-1].op_r;
      end

      for (genvar i = 0; i < NO; i++) begin : g_pair
         mux_gate_cell #(.W(W)) u_cell (
            .a  (src_data_s[(2*i)*W +: W]),
            .b  (src_data_s[(2*i+1)*W +: W]),
            .op (src_op_s),
            .y  (res_s[i*W +: W])
         );
      end

      assign rdy_s[j] = ~valid_r | rdy_s[j+1];

      // Stage register: advances whenever it is empty or its successor drains.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            valid_r <= 1'b0;
            op_r    <= OP_OR;
            data_r  <= '0;
         end else if (rdy_s[j]) begin
            valid_r <= src_valid_s;
            op_r    <= src_op_s;
            data_r  <= res_s;
         end
      end
   end

   assign out_valid = g_lvl[LVL-1].valid_r;
   assign out_data  = g_lvl[LVL-1].data_r;
   assign out_op    = g_lvl[LVL-1].op_r;

endmodule
